pwm_duty_meter: RTL and testbench

Measures the duty cycle of a single PWM-dimmed, active-low display line and reports it as a 4-bit brightness level (0–15). It is the receiving end of the segment dimmer: it counts on-cycles over a window equal to the dimmer frame and quantises the count back to the duty word that produced it. It sits on the display side for brightness self-check, auto-calibration and bench loopback of the dimmer.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/sync_2ff.sv | 27 ++
 rtl/pwm_duty_meter.sv | 114 +++++++++++
 tb/tb_pwm_duty_meter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the segment dimmer and the duty meter that reads it
// back. The dimmer frame counts 0..DIM_FRAME-1. Each brightness level is
// worth DIM_STEP on-cycles per frame.
package stopwatch_pkg;

  localparam int unsigned DIM_FRAME     = 15001;
  localparam int unsigned DIM_STEP      = 1000;
  localparam int unsigned DIM_MAX_LEVEL = 15;

  typedef logic [3:0] level_t;

  // Bits needed to hold any value 0..n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, loads RESET_VAL into both flops
//   d    : asynchronous input
//   q    : synchronised output, 2 clk cycles behind d
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// Duty-cycle meter for one PWM-dimmed display line. It counts lit cycles over
// a window of one dimmer frame and divides the count back to a brightness
// level, rounded half up and saturated at MAX_LEVEL.
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   pwm_in        : dimmed segment line, asynchronous to clk
//   level         : last measured brightness 0..MAX_LEVEL, held between updates
//   level_valid   : one-cycle pulse when level is updated (once per window)
//   level_changed : pulses with level_valid when the new level differs
import stopwatch_pkg::*;

module pwm_duty_meter #(
  parameter int unsigned WINDOW     = DIM_FRAME,
  parameter int unsigned STEP       = DIM_STEP,
  parameter int unsigned MAX_LEVEL  = DIM_MAX_LEVEL,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   pwm_in,
  output level_t level,
  output logic   level_valid,
  output logic   level_changed
);

  localparam int unsigned CW = count_width(WINDOW);
  localparam int unsigned RW = CW + 1;

  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
  localparam logic [RW-1:0] STEP_R   = RW'(STEP);
  localparam logic [RW-1:0] HALF_R   = RW'(STEP / 2);
  localparam level_t        MAX_Q    = level_t'(MAX_LEVEL);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DIV  = 1'b1;

  logic          sync_bit;
  logic          on;
  logic          snap_now;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] on_cnt;
  logic [CW-1:0] snap;
  logic [RW-1:0] rem;
  level_t        q;
  logic [0:0]    state;

  sync_2ff #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pwm_in),
    .q   (sync_bit)
  );

  // 1 = segment lit, regardless of line polarity.
  assign on       = sync_bit ^ ACTIVE_LOW;
  assign snap_now = (win_cnt == WIN_LAST);

  // The final cycle of the window is folded into the snapshot, and the
  // divider loads this sum directly, so DIV starts on the very next cycle.
  assign snap = on_cnt + CW'(on);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      on_cnt  <= '0;
    end else if (snap_now) begin
      win_cnt <= '0;
      on_cnt  <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      on_cnt  <= on_cnt + CW'(on);
    end
  end

  // Restoring divide by repeated subtraction; one quotient step per cycle,
  // capped at MAX_LEVEL so large counts saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rem           <= '0;
      q             <= '0;
      level         <= '0;
      level_valid   <= 1'b0;
      level_changed <= 1'b0;
    end else begin
      level_valid   <= 1'b0;
      level_changed <= 1'b0;
      case (state)
        IDLE: begin
          if (snap_now) begin
            rem   <= {1'b0, snap} + HALF_R;
            q     <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          if (rem >= STEP_R && q < MAX_Q) begin
            rem <= rem - STEP_R;
            q   <= q + 1'b1;
          end else begin
            level         <= q;
            level_valid   <= 1'b1;
            level_changed <= (q != level);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter. One instance at the default frame is fed windows
// with a chosen number of lit cycles scattered at random positions; a second
// instance with a 20000-cycle window sees a permanently lit line.
module tb_pwm_duty_meter;
  import stopwatch_pkg::*;

  localparam int unsigned W    = 15001;
  localparam int unsigned STEP = 1000;
  localparam int unsigned MAXL = 15;
  localparam int unsigned W2   = 20000;
  localparam int          D2   = 20016;

  logic   clk    = 1'b0;
  logic   rst    = 1'b1;
  logic   rst2   = 1'b1;
  logic   pwm_in = 1'b1;
  logic   pwm2   = 1'b0;
  level_t level, level2;
  logic   valid, changed, valid2, changed2;

  pwm_duty_meter #(
    .WINDOW     (W),
    .STEP       (STEP),
    .MAX_LEVEL  (MAXL),
    .ACTIVE_LOW (1'b1)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .pwm_in        (pwm_in),
    .level         (level),
    .level_valid   (valid),
    .level_changed (changed)
  );

  pwm_duty_meter #(
    .WINDOW     (W2),
    .STEP       (STEP),
    .MAX_LEVEL  (MAXL),
    .ACTIVE_LOW (1'b1)
  ) u_dut2 (
    .clk           (clk),
    .rst           (rst2),
    .pwm_in        (pwm2),
    .level         (level2),
    .level_valid   (valid2),
    .level_changed (changed2)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state for u_dut.
  int          j;            // cycle index since reset release
  int          j2;           // same for u_dut2 (never reset mid-run)
  int unsigned cnt;          // lit cycles accumulated in current window
  int          due;          // cycle at which the pending result must appear
  int unsigned pend_q;
  int unsigned m_level;
  bit          hist[$];      // lit values driven, awaiting the 2-cycle input latency
  bit          post;         // 0 before the mid-DIV reset, 1 after
  int unsigned remaining;    // lit cycles still to place in the window being driven
  int unsigned k;            // index into the pinned results

  int unsigned tgt_post[4] = '{1499, 1500, 14499, 14500};
  int          pin_due[4]  = '{15003, 30005, 45018, 60020};
  int unsigned pin_lvl[4]  = '{1, 2, 14, 15};

  function automatic int unsigned target(input int unsigned widx);
    if (!post) return (widx == 0) ? 14500 : 0;
    return (widx < 4) ? tgt_post[widx] : 0;
  endfunction

  task automatic reset_model();
    j = 0; cnt = 0; due = -1; pend_q = 0; m_level = 0;
    hist.delete();
    remaining = 0;
  endtask

  task automatic dut2_check();
    bit ev;
    ev = (j2 >= D2) && (((j2 - D2) % int'(W2)) == 0);
    check("sat_level", level2, (j2 >= D2) ? MAXL : 0);
    check("sat_valid", valid2, ev);
    check("sat_changed", changed2, (j2 == D2));
    j2++;
  endtask

  // One cycle: compare outputs for the current cycle, update the model, drive
  // the line for the next sampling edge, then wait for the next negedge.
  task automatic step();
    bit          ev, exp_chg, lit, on;
    int unsigned pos, s, q;
    ev = (due >= 0) && (j == due);
    exp_chg = 1'b0;
    if (ev) begin
      exp_chg = (pend_q != m_level);
      m_level = pend_q;
    end
    check("level", level, m_level);
    check("level_valid", valid, ev);
    check("level_changed", changed, exp_chg);
    if (ev && post && k < 4) begin
      check("pin_time", j, pin_due[k]);
      check("pin_level", level, pin_lvl[k]);
      k++;
    end
    dut2_check();

    on = 1'b0;
    if (hist.size() >= 2) on = hist.pop_front();
    cnt += on;
    if ((j % int'(W)) == int'(W) - 1) begin
      q = (cnt + STEP / 2) / STEP;
      if (q > MAXL) q = MAXL;
      pend_q = q;
      due = j + 2 + int'(q);
      cnt = 0;
    end

    pos = (j + 2) % W;
    if (j == 0 || pos == 0) remaining = target((j + 2) / W);
    s = W - pos;
    lit = ($urandom_range(s - 1, 0) < remaining);
    if (lit) remaining--;
    hist.push_back(lit);
    pwm_in = ~lit;

    j++;
    @(negedge clk);
  endtask

  initial begin
    post = 1'b0; k = 0; j2 = 0;
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_valid", valid, 0);
    check("rst_changed", changed, 0);
    check("rst_level2", level2, 0);
    check("rst_valid2", valid2, 0);

    rst = 1'b0; rst2 = 1'b0;
    repeat (15003) step();

    // Three cycles after the snapshot of a saturating window: still in DIV.
    rst = 1'b1;
    repeat (3) begin
      #1;
      check("div_rst_level", level, 0);
      check("div_rst_valid", valid, 0);
      check("div_rst_changed", changed, 0);
      dut2_check();
      @(negedge clk);
    end
    rst = 1'b0;
    post = 1'b1;
    reset_model();
    repeat (4 * W + 30) step();
    check("pin_count", k, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
